// File: rtl/morse_symbol_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : morse_symbol_rx_if
// Description : Light-line input and symbol/character outputs of the receiver.
// Revision    : 1.0
// ============================================================================
interface morse_symbol_rx_if #(
    parameter int MAX_SYM = 5
);
    logic               led_in;
    logic               sym_valid;
    logic               symbol;
    logic               char_valid;
    logic [MAX_SYM-1:0] char_code;
    logic [2:0]         char_len;
    logic               word_gap;
    logic               err;

    // master: the receiver itself; slave: the light source plus the downstream consumer
    modport master (
        input  led_in,
        output sym_valid, symbol, char_valid, char_code, char_len, word_gap, err
    );
    modport slave (
        output led_in,
        input  sym_valid, symbol, char_valid, char_code, char_len, word_gap, err
    );
endinterface
`default_nettype wire

// File: rtl/morse_symbol_rx.sv
`default_nettype none
// ============================================================================
// Module      : morse_symbol_rx
// Description : Classifies sampled light marks as dot/dash and assembles them
//               into characters, flagging letter and word gaps.
// Revision    : 1.0
// ============================================================================
module morse_symbol_rx #(
    parameter int DOT_MAX    = 1,
    parameter int DASH_MIN   = 2,
    parameter int DASH_MAX   = 3,
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 7,
    parameter int MAX_SYM    = 5
) (
    input logic              clock,
    input logic              reset,
    morse_symbol_rx_if.master bus
);
    localparam int HW = $clog2(DASH_MAX + 2);
    localparam int LW = $clog2(WORD_GAP + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MARK  = 2'd1;
    localparam logic [1:0] SPACE = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam logic [HW-1:0] HI_SAT       = HW'(DASH_MAX + 1);
    localparam logic [HW-1:0] DOT_MAX_C    = HW'(DOT_MAX);
    localparam logic [HW-1:0] DASH_MIN_C   = HW'(DASH_MIN);
    localparam logic [HW-1:0] DASH_MAX_C   = HW'(DASH_MAX);
    localparam logic [LW-1:0] LETTER_GAP_C = LW'(LETTER_GAP);
    localparam logic [LW-1:0] WORD_GAP_C   = LW'(WORD_GAP);
    localparam logic [2:0]    MAX_SYM_C    = 3'(MAX_SYM);

    logic [1:0]         state;
    logic [HW-1:0]      hi_cnt;
    logic [LW-1:0]      lo_cnt;
    logic [MAX_SYM-1:0] sr;
    logic [2:0]         len;

    logic               is_dot;
    logic               is_dash;
    logic               sym_ok;
    logic [LW-1:0]      lo_inc;
    logic [MAX_SYM:0]   sr_ext;

    always_comb begin
        is_dot  = (hi_cnt != '0) && (hi_cnt <= DOT_MAX_C);
        is_dash = (hi_cnt >= DASH_MIN_C) && (hi_cnt <= DASH_MAX_C);
        sym_ok  = (is_dot || is_dash) && (len < MAX_SYM_C);
        lo_inc  = (lo_cnt == WORD_GAP_C) ? lo_cnt : lo_cnt + LW'(1);
        // widened shift keeps the newest symbol at bit0 even when MAX_SYM is 1
        sr_ext  = {sr, is_dash};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            hi_cnt         <= '0;
            lo_cnt         <= '0;
            sr             <= '0;
            len            <= '0;
            bus.sym_valid  <= 1'b0;
            bus.symbol     <= 1'b0;
            bus.char_valid <= 1'b0;
            bus.char_code  <= '0;
            bus.char_len   <= '0;
            bus.word_gap   <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.sym_valid  <= 1'b0;
            bus.char_valid <= 1'b0;
            bus.word_gap   <= 1'b0;
            bus.err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.led_in) begin
                        state  <= MARK;
                        hi_cnt <= HW'(1);
                    end
                end
                MARK: begin
                    if (bus.led_in) begin
                        if (hi_cnt != HI_SAT) hi_cnt <= hi_cnt + HW'(1);
                    end else if (sym_ok) begin
                        bus.sym_valid <= 1'b1;
                        bus.symbol    <= is_dash;
                        sr            <= sr_ext[MAX_SYM-1:0];
                        len           <= len + 3'd1;
                        state         <= SPACE;
                        lo_cnt        <= LW'(1);
                    end else begin
                        // overlong mark or too many symbols: drop the whole character
                        bus.err <= 1'b1;
                        sr      <= '0;
                        len     <= '0;
                        state   <= IDLE;
                    end
                end
                SPACE: begin
                    if (bus.led_in) begin
                        state  <= MARK;
                        hi_cnt <= HW'(1);
                    end else begin
                        lo_cnt <= lo_inc;
                        if (lo_inc == LETTER_GAP_C) begin
                            bus.char_valid <= 1'b1;
                            bus.char_code  <= sr;
                            bus.char_len   <= len;
                            sr             <= '0;
                            len            <= '0;
                            state          <= GAP;
                        end
                    end
                end
                default: begin
                    if (bus.led_in) begin
                        state  <= MARK;
                        hi_cnt <= HW'(1);
                    end else begin
                        lo_cnt <= lo_inc;
                        if (lo_inc == WORD_GAP_C) begin
                            bus.word_gap <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_morse_symbol_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_symbol_rx
// Description : Self-checking bench for morse_symbol_rx (cycle-exact scoreboard).
// Revision    : 1.0
// ============================================================================
module tb_morse_symbol_rx;
    localparam int EV_NONE = 0;
    localparam int EV_DOT  = 1;
    localparam int EV_DASH = 2;
    localparam int EV_CHAR = 3;
    localparam int EV_WORD = 4;
    localparam int EV_ERR  = 5;

    typedef struct {
        bit         rst;
        bit         led;
        int         ev;
        logic [4:0] code;
        logic [2:0] len;
    } vec_t;

    typedef struct {
        logic       sv;
        logic       sym;
        logic       cv;
        logic [4:0] code;
        logic [2:0] len;
        logic       wg;
        logic       er;
        int         idx;
    } exp_t;

    logic clock;
    logic reset;
    morse_symbol_rx_if #(.MAX_SYM(5)) bus ();

    morse_symbol_rx #(
        .DOT_MAX(1), .DASH_MIN(2), .DASH_MAX(3),
        .LETTER_GAP(3), .WORD_GAP(7), .MAX_SYM(5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    vec_t       tbl[$];
    exp_t       sb[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    int         row_idx = 0;
    logic       h_sym = 1'b0;
    logic [4:0] h_code = '0;
    logic [2:0] h_len = '0;

    function automatic void add(bit r, bit l, int ev, logic [4:0] c = 5'd0, logic [2:0] n = 3'd0);
        vec_t v;
        v.rst = r; v.led = l; v.ev = ev; v.code = c; v.len = n;
        tbl.push_back(v);
    endfunction

    function automatic void hi(int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b1, EV_NONE);
    endfunction

    function automatic void lo(int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, EV_NONE);
    endfunction

    // Drive one edge and queue the outputs expected right after it; held values tracked here.
    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clock);
        reset      = v.rst;
        bus.led_in = v.led;
        if (v.rst) begin
            h_sym = 1'b0; h_code = '0; h_len = '0;
        end else begin
            if (v.ev == EV_DOT)  h_sym = 1'b0;
            if (v.ev == EV_DASH) h_sym = 1'b1;
            if (v.ev == EV_CHAR) begin h_code = v.code; h_len = v.len; end
        end
        e.sv   = !v.rst && (v.ev == EV_DOT || v.ev == EV_DASH);
        e.sym  = h_sym;
        e.cv   = !v.rst && (v.ev == EV_CHAR);
        e.code = h_code;
        e.len  = h_len;
        e.wg   = !v.rst && (v.ev == EV_WORD);
        e.er   = !v.rst && (v.ev == EV_ERR);
        e.idx  = row_idx;
        row_idx++;
        sb.push_back(e);
    endtask

    task automatic s(input bit r, input bit l, input int ev, input logic [4:0] c = 5'd0,
                     input logic [2:0] n = 3'd0);
        vec_t v;
        v.rst = r; v.led = l; v.ev = ev; v.code = c; v.len = n;
        step(v);
    endtask

    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({bus.sym_valid, bus.symbol, bus.char_valid, bus.char_code, bus.char_len,
                 bus.word_gap, bus.err} !==
                {mon_e.sv, mon_e.sym, mon_e.cv, mon_e.code, mon_e.len, mon_e.wg, mon_e.er}) begin
                errors++;
                $display("FAIL row%0d: got sv=%b sym=%b cv=%b code=%b len=%0d wg=%b err=%b, required sv=%b sym=%b cv=%b code=%b len=%0d wg=%b err=%b",
                         mon_e.idx, bus.sym_valid, bus.symbol, bus.char_valid, bus.char_code,
                         bus.char_len, bus.word_gap, bus.err, mon_e.sv, mon_e.sym, mon_e.cv,
                         mon_e.code, mon_e.len, mon_e.wg, mon_e.er);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        bus.led_in = 1'b0;

        add(1'b1, 1'b0, EV_NONE); add(1'b1, 1'b0, EV_NONE);
        // E, then silence to a word gap
        hi(1); add(0, 0, EV_DOT); lo(1); add(0, 0, EV_CHAR, 5'b00000, 3'd1); lo(3); add(0, 0, EV_WORD);
        // A
        hi(1); add(0, 0, EV_DOT); hi(3); add(0, 0, EV_DASH); lo(1);
        add(0, 0, EV_CHAR, 5'b00001, 3'd2); lo(3); add(0, 0, EV_WORD);
        // T, word gap, then one word gap only
        hi(3); add(0, 0, EV_DASH); lo(1); add(0, 0, EV_CHAR, 5'b00001, 3'd1);
        lo(3); add(0, 0, EV_WORD); lo(5);
        // K with a 2-sample dash
        hi(3); add(0, 0, EV_DASH); hi(1); add(0, 0, EV_DOT); hi(2); add(0, 0, EV_DASH); lo(1);
        add(0, 0, EV_CHAR, 5'b00101, 3'd3); lo(3); add(0, 0, EV_WORD);
        // '1': exactly MAX_SYM symbols
        hi(1); add(0, 0, EV_DOT);
        for (int k = 0; k < 4; k++) begin hi(3); add(0, 0, EV_DASH); end
        lo(1); add(0, 0, EV_CHAR, 5'b01111, 3'd5); lo(3); add(0, 0, EV_WORD);
        // overlong marks, IDLE stays silent
        hi(4); add(0, 0, EV_ERR); lo(2); hi(6); add(0, 0, EV_ERR); lo(7);
        // mark during GAP starts a new character without a word gap
        hi(1); add(0, 0, EV_DOT); lo(1); add(0, 0, EV_CHAR, 5'b00000, 3'd1); lo(1);
        hi(1); add(0, 0, EV_DOT); lo(1); add(0, 0, EV_CHAR, 5'b00000, 3'd1); lo(3); add(0, 0, EV_WORD);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // symbol overflow, then a fresh character must not carry old symbols
        for (int k = 0; k < 5; k++) begin s(0, 1, EV_NONE); s(0, 0, EV_DOT); end
        s(0, 1, EV_NONE); s(0, 0, EV_ERR);
        for (int k = 0; k < 3; k++) s(0, 0, EV_NONE);
        s(0, 1, EV_NONE); s(0, 1, EV_NONE); s(0, 0, EV_DASH); s(0, 0, EV_NONE);
        s(0, 0, EV_CHAR, 5'b00001, 3'd1);
        for (int k = 0; k < 3; k++) s(0, 0, EV_NONE);
        s(0, 0, EV_WORD);

        // reset mid-mark discards everything
        s(0, 1, EV_NONE); s(0, 1, EV_NONE); s(1, 1, EV_NONE); s(1, 1, EV_NONE);
        for (int k = 0; k < 8; k++) s(0, 0, EV_NONE);

        // led high on the first edge after reset release starts a mark
        s(1, 0, EV_NONE); s(0, 1, EV_NONE); s(0, 0, EV_DOT); s(0, 0, EV_NONE);
        s(0, 0, EV_CHAR, 5'b00000, 3'd1);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clock);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
